pixel_merge_buffer: RTL and testbench
=====================================

Name: pixel_merge_buffer

Overview:
- Parametrised successor to the two-core pixel buffer. Merges pixel streams from up to NUM_CORES ray-processor cores into one raster-ordered output stream with SOF/EOL framing.
- Core k renders linear pixel indices i where i mod active_cores == k. Each core has a private FWFT FIFO; a round-robin read pointer restores raster order.
- Sits between the RayProcessor cores and the external video stream interface.

Parameters:
- NUM_CORES, 4, number of core input lanes (1..8).
- FIFO_DEPTH, 8, entries per lane FIFO (power of two, >=2).
- DIM_W, 13, width of image dimension inputs and pixel counters.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- active_cores  in  4  number of lanes in use (1..NUM_CORES); sampled at frame start
- image_width  in  DIM_W  pixels per row; sampled at frame start
- image_height  in  DIM_W  rows per frame; sampled at frame start
- in_rgb  in  24*NUM_CORES  lane k pixel at bits [24k+23:24k], {r,g,b}
- in_valid  in  NUM_CORES  lane k pixel valid
- in_ready  out  NUM_CORES  lane k FIFO can accept
- out_rgb  out  24  merged pixel {r,g,b}
- out_valid  out  1  out_rgb valid
- out_ready  in  1  downstream accept
- SOF_out  out  1  first pixel of frame, qualified by out_valid
- EOL_out  out  1  last pixel of row, qualified by out_valid
- frame_done  out  1  one-cycle pulse after the last pixel of a frame transfers
- frame_count  out  16  completed frames, wraps at 65535 -> 0

Behaviour:
- Reset (async assert, released on the next clk edge):
  - All FIFOs empty; rd_ptr=0; x=0; y=0.
  - frame_count=0; frame_done=0; out_valid=0; in_ready=0 for the cycle reset is high.
  - Latched configuration loaded on the first clk edge after release.
- Config latch:
  - active_cores, image_width and image_height are captured when a frame starts: the first cycle after reset and the cycle after the final pixel of a frame transfers.
  - Values are held for the whole frame; mid-frame input changes are ignored.
  - active_cores of 0 is treated as 1; values >NUM_CORES are clamped to NUM_CORES.
  - Width or height of 0 is treated as 1.
- Lane write:
  - in_ready[k] = !full[k] && (k < latched active_cores).
  - A push occurs when in_valid[k] && in_ready[k].
  - Unused lanes hold in_ready=0 and their data is dropped.
- Output:
  - out_valid = !empty[rd_ptr]; out_rgb = head of FIFO[rd_ptr] (FWFT, combinational from the storage head).
  - Latency: a pixel pushed in cycle t is visible at the output in cycle t+1 if its lane is selected.
- Transfer:
  - A transfer occurs when out_valid && out_ready: pop FIFO[rd_ptr].
  - rd_ptr increments, wrapping to 0 after latched active_cores-1.
  - x increments; at x==width-1, x returns to 0 and y increments.
  - At x==width-1 && y==height-1: x=0, y=0, rd_ptr=0, frame_count++, frame_done=1 next cycle, config re-latched.
- Framing:
  - SOF_out = out_valid && x==0 && y==0.
  - EOL_out = out_valid && x==width-1.
  - When width==1 and height==1, SOF and EOL are asserted together on the same pixel.
- Output stalls:
  - With out_ready low, out_rgb/SOF/EOL are held stable while out_valid is high.
  - out_valid must not drop without a transfer, since FIFOs only pop on transfer.
- Simultaneous events:
  - A push and pop on the same FIFO in one cycle are both performed; occupancy is unchanged.
  - A push to a full FIFO cannot occur, because in_ready is 0.
  - A pop from an empty FIFO cannot occur, because out_valid is 0.
- Other lanes' FIFOs fill independently while the selected lane is empty; this is the head-of-line wait, and no reordering is allowed.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide with a wrap bit; full/empty are derived from the pointers, and there is no separate count register.
- Reset mid-frame: all buffered pixels are discarded; the next output pixel carries SOF.

Test Plan:
- NUM_CORES=4, active=4, 4x2 image, each lane pushes its two pixels (lane k values 0x0000k0, 0x0000k4) -> output order lane0,1,2,3,0,1,2,3; SOF on beat 0; EOL on beats 3 and 7; frame_done pulse; frame_count=1.
- active=2, 3x1 image, lane1 pushes before lane0 -> out_valid stays 0 until lane0 pushes; output order L0,L1,L0; lanes 2,3 in_ready=0 throughout.
- Hold out_ready=0, lane0 pushes FIFO_DEPTH pixels -> in_ready[0]=0 after 8 pushes; assert out_ready -> 8 beats in order, ready returns 1 after first pop.
- Change image_width 4->2 mid-frame -> current frame still EOLs every 4 pixels; next frame EOLs every 2.
- Assert reset after 5 of 8 pixels transferred -> outputs cleared immediately; after release, next transferred pixel has SOF=1 and comes from lane0.
- width=1, height=1, active=1 -> every beat has SOF=EOL=1; frame_count increments per beat; wraps 65535->0.

Source files
------------

// File: rtl/pixel_merge_buffer_if.sv
// -----------------------------------------------------------------------------
// pixel_merge_buffer_if
//
// Groups every non-clock/reset signal of pixel_merge_buffer. Names carry the
// direction as seen from the buffer (i_ = into the buffer, o_ = out of it).
//
//   Configuration (sampled by the buffer at frame start)
//     i_active_cores  [3:0]              number of lanes in use
//     i_image_width   [DIM_W-1:0]        pixels per row
//     i_image_height  [DIM_W-1:0]        rows per frame
//   Core input lanes
//     i_in_rgb        [24*NUM_CORES-1:0] lane k pixel at [24k+23:24k], {r,g,b}
//     i_in_valid      [NUM_CORES-1:0]    lane k pixel valid
//     o_in_ready      [NUM_CORES-1:0]    lane k FIFO can accept
//   Merged output stream
//     o_out_rgb       [23:0]             merged pixel
//     o_out_valid                        o_out_rgb valid
//     i_out_ready                        downstream accept
//     o_sof_out                          first pixel of frame
//     o_eol_out                          last pixel of row
//   Status
//     o_frame_done                       one-cycle pulse after a frame completes
//     o_frame_count   [15:0]             completed frames, wrapping
//
// Modports: slave = the buffer, master = whatever drives it (cores + sink).
// -----------------------------------------------------------------------------
interface pixel_merge_buffer_if #(
    parameter int NUM_CORES = 4,
    parameter int DIM_W     = 13
);
    logic [3:0]              i_active_cores;
    logic [DIM_W-1:0]        i_image_width;
    logic [DIM_W-1:0]        i_image_height;
    logic [24*NUM_CORES-1:0] i_in_rgb;
    logic [NUM_CORES-1:0]    i_in_valid;
    logic [NUM_CORES-1:0]    o_in_ready;
    logic [23:0]             o_out_rgb;
    logic                    o_out_valid;
    logic                    i_out_ready;
    logic                    o_sof_out;
    logic                    o_eol_out;
    logic                    o_frame_done;
    logic [15:0]             o_frame_count;

    modport slave (
        input  i_active_cores, i_image_width, i_image_height,
        input  i_in_rgb, i_in_valid, i_out_ready,
        output o_in_ready, o_out_rgb, o_out_valid, o_sof_out, o_eol_out,
        output o_frame_done, o_frame_count
    );

    modport master (
        output i_active_cores, i_image_width, i_image_height,
        output i_in_rgb, i_in_valid, i_out_ready,
        input  o_in_ready, o_out_rgb, o_out_valid, o_sof_out, o_eol_out,
        input  o_frame_done, o_frame_count
    );
endinterface

// File: rtl/pixel_merge_buffer.sv
// -----------------------------------------------------------------------------
// pixel_merge_buffer
//
// Merges the pixel streams of up to NUM_CORES ray-processor cores into one
// raster-ordered stream with SOF/EOL framing. Core k renders the linear pixel
// indices i with i mod active_cores == k; each core writes into a private
// first-word-fall-through FIFO and a round-robin read pointer walks the lanes
// in index order, so the output is raster ordered without any reordering
// logic. If the selected lane is empty the output simply waits (head-of-line
// wait) while the other lanes keep filling.
//
// Ports
//   clk   clock
//   rst   asynchronous active-high reset; discards all buffered pixels
//   bus   pixel_merge_buffer_if.slave (configuration, lanes, output, status)
//
// Parameters
//   NUM_CORES   number of core lanes (1..8)
//   FIFO_DEPTH  entries per lane FIFO (power of two, >= 2)
//   DIM_W       width of image dimensions and pixel counters
// -----------------------------------------------------------------------------
module pixel_merge_buffer #(
    parameter int NUM_CORES  = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int DIM_W      = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    pixel_merge_buffer_if.slave   bus
);

    // FIFO address width; pointers carry one extra wrap bit so that full and
    // empty can be told apart without an occupancy counter.
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    localparam logic [3:0]       MAX_ACTIVE = 4'(NUM_CORES);
    localparam logic [DIM_W-1:0] DIM_ONE    = {{(DIM_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [23:0]       r_mem  [NUM_CORES][FIFO_DEPTH];
    logic [PW-1:0]     r_wptr [NUM_CORES];
    logic [PW-1:0]     r_rptr [NUM_CORES];

    logic [LW-1:0]     r_rd_ptr;        // lane holding the next raster pixel
    logic [DIM_W-1:0]  r_x;
    logic [DIM_W-1:0]  r_y;

    logic              r_cfg_loaded;    // low until the first post-reset edge
    logic [3:0]        r_active;        // 0 while unloaded => all lanes closed
    logic [DIM_W-1:0]  r_width;
    logic [DIM_W-1:0]  r_height;

    logic [15:0]       r_frame_count;
    logic              r_frame_done;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [NUM_CORES-1:0] w_empty;
    logic [NUM_CORES-1:0] w_full;
    logic [NUM_CORES-1:0] w_lane_en;
    logic [NUM_CORES-1:0] w_in_ready;
    logic [NUM_CORES-1:0] w_push;
    logic [NUM_CORES-1:0] w_pop;

    logic                 w_out_valid;
    logic [23:0]          w_head;
    logic                 w_xfer;
    logic                 w_x_last;
    logic                 w_y_last;
    logic                 w_frame_last;
    logic                 w_rd_last;
    logic                 w_cfg_load;

    logic [3:0]           w_active_in;
    logic [DIM_W-1:0]     w_width_in;
    logic [DIM_W-1:0]     w_height_in;

    // Sanitised configuration inputs: zero lanes/dimensions become one,
    // lane counts beyond the instantiated cores are clamped.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_active_in = bus.i_active_cores;
        if (bus.i_active_cores == 4'd0) begin
            w_active_in = 4'd1;
        end else if (bus.i_active_cores > MAX_ACTIVE) begin
            w_active_in = MAX_ACTIVE;
        end
        w_width_in  = (bus.i_image_width  == '0) ? DIM_ONE : bus.i_image_width;
        w_height_in = (bus.i_image_height == '0) ? DIM_ONE : bus.i_image_height;
    end

    // Per-lane status, write acceptance and pop selection.
    always_comb begin
        w_empty    = '0;
        w_full     = '0;
        w_lane_en  = '0;
        w_in_ready = '0;
        w_push     = '0;
        w_pop      = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            w_empty[k]    = (r_wptr[k] == r_rptr[k]);
            // Same slot, opposite wrap bit: the writer has lapped the reader.
            w_full[k]     = (r_wptr[k][AW] != r_rptr[k][AW]) &&
                            (r_wptr[k][AW-1:0] == r_rptr[k][AW-1:0]);
            w_lane_en[k]  = (4'(k) < r_active);
            w_in_ready[k] = !w_full[k] && w_lane_en[k];
            w_push[k]     = bus.i_in_valid[k] && w_in_ready[k];
            w_pop[k]      = w_xfer && (r_rd_ptr == LW'(k));
        end
    end

    // First-word-fall-through head of the selected lane drives the output
    // directly, so a pixel written in cycle t is visible in cycle t+1.
    assign w_out_valid  = !w_empty[r_rd_ptr];
    assign w_head       = r_mem[r_rd_ptr][r_rptr[r_rd_ptr][AW-1:0]];
    assign w_xfer       = w_out_valid && bus.i_out_ready;

    assign w_x_last     = (r_x == r_width  - DIM_ONE);
    assign w_y_last     = (r_y == r_height - DIM_ONE);
    assign w_frame_last = w_x_last && w_y_last;
    assign w_rd_last    = (4'(r_rd_ptr) == r_active - 4'd1);

    // Configuration is (re)captured on the first edge after reset and on the
    // edge that moves the final pixel of a frame, then held for the frame.
    assign w_cfg_load   = !r_cfg_loaded || (w_xfer && w_frame_last);

    // ------------------------------------------------------------------
    // Lane FIFO storage
    // NOTE: the data array has no reset; an entry is only ever read after
    // it has been written, and the reset pointers make every lane empty.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_CORES; k++) begin
            if (w_push[k]) begin
                r_mem[k][r_wptr[k][AW-1:0]] <= bus.i_in_rgb[24*k +: 24];
            end
        end
    end

    // Lane FIFO pointers. A push and a pop on the same lane in one cycle
    // both advance, leaving occupancy unchanged.
    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_CORES; k++) begin
                r_wptr[k] <= '0;
                r_rptr[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CORES; k++) begin
                if (w_push[k]) begin
                    r_wptr[k] <= r_wptr[k] + PW'(1);
                end
                if (w_pop[k]) begin
                    r_rptr[k] <= r_rptr[k] + PW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Raster position, lane selection and frame accounting
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr      <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_frame_count <= '0;
            r_frame_done  <= 1'b0;
        end else begin
            r_frame_done <= w_xfer && w_frame_last;
            if (w_xfer) begin
                if (w_frame_last) begin
                    // Frame complete: next pixel is index 0, owned by lane 0.
                    r_rd_ptr      <= '0;
                    r_x           <= '0;
                    r_y           <= '0;
                    r_frame_count <= r_frame_count + 16'd1;
                end else begin
                    r_rd_ptr <= w_rd_last ? '0 : r_rd_ptr + LW'(1);
                    if (w_x_last) begin
                        r_x <= '0;
                        r_y <= r_y + DIM_ONE;
                    end else begin
                        r_x <= r_x + DIM_ONE;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame configuration latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cfg_loaded <= 1'b0;
            r_active     <= 4'd0;
            r_width      <= DIM_ONE;
            r_height     <= DIM_ONE;
        end else if (w_cfg_load) begin
            r_cfg_loaded <= 1'b1;
            r_active     <= w_active_in;
            r_width      <= w_width_in;
            r_height     <= w_height_in;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.o_in_ready    = w_in_ready;
    assign bus.o_out_valid   = w_out_valid;
    assign bus.o_out_rgb     = w_head;
    assign bus.o_sof_out     = w_out_valid && (r_x == '0) && (r_y == '0);
    assign bus.o_eol_out     = w_out_valid && w_x_last;
    assign bus.o_frame_done  = r_frame_done;
    assign bus.o_frame_count = r_frame_count;

endmodule

// File: tb/tb_pixel_merge_buffer.sv
// -----------------------------------------------------------------------------
// tb_pixel_merge_buffer
//
// Directed bench for pixel_merge_buffer. A queue-based model tracks, per lane,
// the pixels accepted and, for the frame, the linear index of the next output
// pixel; expected outputs follow from index mod active (lane), index mod width
// (row end) and index == 0 (frame start). One negedge process compares every
// output against the model each cycle; each scenario also checks a short list
// of hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_pixel_merge_buffer;

    localparam int NUM_CORES  = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int DIM_W      = 13;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    pixel_merge_buffer_if #(.NUM_CORES(NUM_CORES), .DIM_W(DIM_W)) bus ();

    pixel_merge_buffer #(
        .NUM_CORES (NUM_CORES),
        .FIFO_DEPTH(FIFO_DEPTH),
        .DIM_W     (DIM_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [23:0] rgb;
        logic        sof;
        logic        eol;
    } beat_t;

    beat_t       log_q[$];        // first transferred beats since last reset
    int          n_xfer   = 0;
    int          fd_seen  = 0;
    bit          wrapped  = 1'b0;
    logic [15:0] prev_fc  = '0;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [23:0] mq [NUM_CORES][$];
    int          m_pix    = 0;    // linear index of next output pixel in frame
    int          m_active = 0;
    int          m_w      = 1;
    int          m_h      = 1;
    bit          m_loaded = 1'b0;
    logic [15:0] m_fc     = '0;
    bit          m_fd     = 1'b0;

    int          u_lane;
    bit          u_valid;
    bit          u_last;
    bit          u_rdy [NUM_CORES];

    function automatic int sat_active(input logic [3:0] a);
        if (a == 4'd0) return 1;
        if (int'(a) > NUM_CORES) return NUM_CORES;
        return int'(a);
    endfunction

    function automatic int sat_dim(input logic [DIM_W-1:0] d);
        return (d == '0) ? 1 : int'(d);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_CORES; k++) mq[k].delete();
            m_pix    = 0;
            m_fc     = '0;
            m_fd     = 1'b0;
            m_loaded = 1'b0;
            m_active = 0;
            m_w      = 1;
            m_h      = 1;
        end else begin
            u_lane  = (m_active > 0) ? (m_pix % m_active) : 0;
            u_valid = m_loaded && (mq[u_lane].size() > 0);
            for (int k = 0; k < NUM_CORES; k++)
                u_rdy[k] = m_loaded && (k < m_active) && (mq[k].size() < FIFO_DEPTH);
            u_last = 1'b0;
            if (u_valid && bus.i_out_ready) begin
                void'(mq[u_lane].pop_front());
                m_pix++;
                if (m_pix == m_w * m_h) begin
                    m_pix  = 0;
                    m_fc   = m_fc + 16'd1;
                    u_last = 1'b1;
                end
            end
            for (int k = 0; k < NUM_CORES; k++)
                if (u_rdy[k] && bus.i_in_valid[k]) mq[k].push_back(bus.i_in_rgb[24*k +: 24]);
            m_fd = u_last;
            if (!m_loaded || u_last) begin
                m_active = sat_active(bus.i_active_cores);
                m_w      = sat_dim(bus.i_image_width);
                m_h      = sat_dim(bus.i_image_height);
                m_loaded = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare, away from the active edge
    // ------------------------------------------------------------------
    int                   c_lane;
    bit                   c_valid;
    logic [NUM_CORES-1:0] c_ready;

    always @(negedge clk) begin
        c_lane  = (m_active > 0) ? (m_pix % m_active) : 0;
        c_valid = m_loaded && (mq[c_lane].size() > 0);
        for (int k = 0; k < NUM_CORES; k++)
            c_ready[k] = m_loaded && (k < m_active) && (mq[k].size() < FIFO_DEPTH);
        check("in_ready",    bus.o_in_ready,    c_ready);
        check("out_valid",   bus.o_out_valid,   c_valid);
        check("frame_done",  bus.o_frame_done,  m_fd);
        check("frame_count", bus.o_frame_count, m_fc);
        if (c_valid) begin
            check("out_rgb", bus.o_out_rgb, mq[c_lane][0]);
            check("sof",     bus.o_sof_out, (m_pix == 0));
            check("eol",     bus.o_eol_out, ((m_pix % m_w) == m_w - 1));
        end
        if (bus.o_out_valid && bus.i_out_ready) begin
            n_xfer++;
            if (log_q.size() < 64) log_q.push_back('{bus.o_out_rgb, bus.o_sof_out, bus.o_eol_out});
        end
        if (bus.o_frame_done) fd_seen++;
        if (prev_fc == 16'hFFFF && bus.o_frame_count == 16'h0000) wrapped = 1'b1;
        prev_fc = bus.o_frame_count;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [3:0] a, input int w, input int h);
        rst                = 1'b1;
        bus.i_in_valid     = '0;
        bus.i_out_ready    = 1'b0;
        bus.i_active_cores = a;
        bus.i_image_width  = DIM_W'(w);
        bus.i_image_height = DIM_W'(h);
        tick();
        tick();
        check("rst_in_ready",    bus.o_in_ready,    '0);
        check("rst_out_valid",   bus.o_out_valid,   1'b0);
        check("rst_frame_count", bus.o_frame_count, 16'd0);
        check("rst_frame_done",  bus.o_frame_done,  1'b0);
        rst = 1'b0;
        log_q.delete();
        n_xfer  = 0;
        fd_seen = 0;
        wrapped = 1'b0;
        tick();
    endtask

    task automatic push(input int lane, input logic [23:0] rgb);
        int guard;
        guard = 0;
        bus.i_in_rgb[24*lane +: 24] = rgb;
        bus.i_in_valid[lane]        = 1'b1;
        while (!bus.o_in_ready[lane] && guard < 200) begin
            tick();
            guard++;
        end
        check("push_accept", bus.o_in_ready[lane], 1'b1);
        tick();
        bus.i_in_valid[lane] = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int guard;
        guard = 0;
        while (log_q.size() < n && guard < 500) begin
            tick();
            guard++;
        end
        check("beats_received", log_q.size(), n);
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    logic [23:0] exp1 [8] = '{24'h000000, 24'h000010, 24'h000020, 24'h000030,
                              24'h000004, 24'h000014, 24'h000024, 24'h000034};
    logic [23:0] exp2 [3] = '{24'hBB0000, 24'hAA0001, 24'hBB0002};
    logic [11:0] eol4     = 12'b1010_1000_1000;   // bit i = EOL on beat i
    int          n6;
    int          g6;
    bit          r6;

    initial begin
        bus.i_in_rgb       = '0;
        bus.i_in_valid     = '0;
        bus.i_out_ready    = 1'b0;
        bus.i_active_cores = 4'd4;
        bus.i_image_width  = DIM_W'(4);
        bus.i_image_height = DIM_W'(2);
        #1 rst = 1'b1;

        // 1: four lanes, 4x2 frame, lane k pixels 0x0000k0 then 0x0000k4.
        apply_reset(4'd4, 4, 2);
        bus.i_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(i % 4, exp1[i]);
        wait_beats(8);
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            check("t1_rgb", log_q[i].rgb, exp1[i]);
            check("t1_sof", log_q[i].sof, (i == 0));
            check("t1_eol", log_q[i].eol, (i == 3 || i == 7));
        end
        check("t1_frame_done_pulses", fd_seen, 1);
        check("t1_frame_count", bus.o_frame_count, 16'd1);

        // 2: two lanes, 3x1 frame, lane 1 arrives first and must wait.
        apply_reset(4'd2, 3, 1);
        bus.i_out_ready = 1'b1;
        push(1, 24'hAA0001);
        for (int i = 0; i < 3; i++) begin
            check("t2_hol_wait", bus.o_out_valid, 1'b0);
            check("t2_unused_ready", bus.o_in_ready[3:2], 2'b00);
            tick();
        end
        push(0, 24'hBB0000);
        push(0, 24'hBB0002);
        wait_beats(3);
        tick();
        for (int i = 0; i < 3; i++) check("t2_rgb", log_q[i].rgb, exp2[i]);
        check("t2_frame_count", bus.o_frame_count, 16'd1);

        // 3: fill lane 0 with the output stalled, then drain.
        apply_reset(4'd1, 8, 1);
        for (int i = 0; i < FIFO_DEPTH; i++) push(0, 24'hC00000 + 24'(i));
        check("t3_full_ready", bus.o_in_ready[0], 1'b0);
        check("t3_stall_valid", bus.o_out_valid, 1'b1);
        check("t3_stall_rgb", bus.o_out_rgb, 24'hC00000);
        tick();
        check("t3_hold_rgb", bus.o_out_rgb, 24'hC00000);
        check("t3_hold_sof", bus.o_sof_out, 1'b1);
        bus.i_out_ready = 1'b1;
        tick();
        check("t3_ready_after_pop", bus.o_in_ready[0], 1'b1);
        wait_beats(8);
        for (int i = 0; i < 8; i++) begin
            check("t3_rgb", log_q[i].rgb, 24'hC00000 + 24'(i));
            check("t3_eol", log_q[i].eol, (i == 7));
        end

        // 4: width 4 -> 2 mid-frame; change only affects the next frame.
        apply_reset(4'd1, 4, 2);
        bus.i_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) push(0, 24'hE00000 + 24'(i));
        bus.i_image_width = DIM_W'(2);
        for (int i = 3; i < 12; i++) push(0, 24'hE00000 + 24'(i));
        wait_beats(12);
        tick();
        for (int i = 0; i < 12; i++) begin
            check("t4_eol", log_q[i].eol, eol4[i]);
            check("t4_sof", log_q[i].sof, (i == 0 || i == 8));
        end
        check("t4_frame_count", bus.o_frame_count, 16'd2);

        // 5: reset after 5 of 8 pixels; next pixel restarts the frame.
        apply_reset(4'd4, 4, 2);
        for (int i = 0; i < 8; i++) push(i % 4, {8'h50, 8'(i), 8'h00});
        bus.i_out_ready = 1'b1;
        repeat (5) tick();
        bus.i_out_ready = 1'b0;
        check("t5_beats_before_reset", log_q.size(), 5);
        rst = 1'b1;
        #1;
        check("t5_async_valid", bus.o_out_valid, 1'b0);
        check("t5_async_ready", bus.o_in_ready, '0);
        tick();
        rst = 1'b0;
        log_q.delete();
        tick();
        bus.i_out_ready = 1'b1;
        push(1, 24'hD10000);
        push(0, 24'hD00000);
        wait_beats(2);
        check("t5_first_rgb", log_q[0].rgb, 24'hD00000);
        check("t5_first_sof", log_q[0].sof, 1'b1);
        check("t5_second_rgb", log_q[1].rgb, 24'hD10000);

        // 6: 1x1 frames, one lane; stream until the frame counter wraps.
        apply_reset(4'd1, 1, 1);
        bus.i_out_ready   = 1'b1;
        bus.i_in_rgb[23:0] = 24'd0;
        bus.i_in_valid[0] = 1'b1;
        n6 = 0;
        g6 = 0;
        while (n6 < 65537 && g6 < 70000) begin
            r6 = bus.o_in_ready[0];
            tick();
            g6++;
            if (r6) begin
                n6++;
                bus.i_in_rgb[23:0] = 24'(n6);
            end
        end
        bus.i_in_valid[0] = 1'b0;
        repeat (4) tick();
        check("t6_pushes", n6, 65537);
        check("t6_transfers", n_xfer, 65537);
        for (int i = 0; i < 4; i++) begin
            check("t6_sof", log_q[i].sof, 1'b1);
            check("t6_eol", log_q[i].eol, 1'b1);
            check("t6_rgb", log_q[i].rgb, 24'(i));
        end
        check("t6_wrapped", wrapped, 1'b1);
        check("t6_frame_count", bus.o_frame_count, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global bound in case a scenario stalls somewhere unexpected.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
